// File: rtl/axis_pkt_gen_pkg.sv
// Shared types and helpers for the AXI4-Stream packet generator.
// Optional tkeep support is enabled with AXIS_PKT_GEN_TKEEP_EN.
package axis_pkt_gen_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } state_t;

  function automatic int unsigned ceil_div(input int unsigned len, input int unsigned bytes);
    return (len + bytes - 1) / bytes;
  endfunction

endpackage

// File: rtl/axis_pkt_gen_fmt.sv
// Combinational beat formatter: lane j carries (base + off + j) mod 256.
// With AXIS_PKT_GEN_TKEEP_EN, lanes past the remaining length are masked and zeroed.
module axis_pkt_gen_fmt
  import axis_pkt_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 8
`ifdef AXIS_PKT_GEN_TKEEP_EN
  ,
  parameter int LEN_WIDTH  = 16
`endif
) (
  input  logic [7:0]                     base,
  input  logic [7:0]                     off,
`ifdef AXIS_PKT_GEN_TKEEP_EN
  input  logic [LEN_WIDTH-1:0]           rem,
  output logic [DATA_WIDTH/BYTE_W-1:0]   keep,
`endif
  output logic [DATA_WIDTH-1:0]          data
);

  localparam int BYTES = DATA_WIDTH / BYTE_W;

  logic [7:0] first_byte;
  assign first_byte = base + off;

  for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
    logic [7:0] lane_val;
    assign lane_val = first_byte + 8'(gi);
`ifdef AXIS_PKT_GEN_TKEEP_EN
    logic lane_en;
    assign lane_en = (32'(rem) > 32'(gi));
    assign keep[gi] = lane_en;
    assign data[gi*BYTE_W +: BYTE_W] = lane_en ? lane_val : 8'h00;
`else
    assign data[gi*BYTE_W +: BYTE_W] = lane_val;
`endif
  end

endmodule

// File: rtl/axis_pkt_gen.sv
// AXI4-Stream packet generator: IDLE/SEND/GAP sequencer with registered stream outputs.
// Define AXIS_PKT_GEN_TKEEP_EN to add m_axis_tkeep and zero the padding lanes.
module axis_pkt_gen
  import axis_pkt_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16,
  parameter int GAP_WIDTH  = 8
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    cfg_start,
  input  logic [LEN_WIDTH-1:0]    cfg_len,
  input  logic [15:0]             cfg_count,
  input  logic [GAP_WIDTH-1:0]    cfg_gap,
  input  logic [7:0]              cfg_seed,
  input  logic                    cfg_stop,
  output logic                    busy,
  output logic                    pkt_done,
  output logic [15:0]             pkt_cnt,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tlast
`ifdef AXIS_PKT_GEN_TKEEP_EN
  ,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep
`endif
);

  localparam int BYTES = DATA_WIDTH / BYTE_W;

  state_t                state_reg;
  logic [LEN_WIDTH-1:0]  beats_reg, beats_left_reg;
  logic [15:0]           count_reg, pkt_cnt_reg;
  logic [GAP_WIDTH-1:0]  gap_reg, gap_cnt_reg;
  logic [7:0]            base_reg, off_reg;
  logic                  stop_pend_reg, pkt_done_reg, tvalid_reg, tlast_reg;
  logic [DATA_WIDTH-1:0] tdata_reg, fmt_data;
`ifdef AXIS_PKT_GEN_TKEEP_EN
  localparam logic [LEN_WIDTH-1:0] BYTES_L = LEN_WIDTH'(BYTES);
  logic [LEN_WIDTH-1:0]  len_reg, rem_reg, nb_rem;
  logic [BYTES-1:0]      tkeep_reg, fmt_keep;
`endif

  logic                  hs, last_hs, more, stop_now, start_ok, ld;
  logic [7:0]            nb_base, nb_off;
  logic [LEN_WIDTH-1:0]  nb_left, start_beats;

  assign start_beats = LEN_WIDTH'(ceil_div(32'(cfg_len), BYTES));

  // The next beat is formatted ahead of time and loaded into the output registers when ld is high.
  always_comb begin
    hs       = tvalid_reg & m_axis_tready;
    last_hs  = hs & tlast_reg;
    more     = (count_reg == 16'd0) || (pkt_cnt_reg + 16'd1 != count_reg);
    stop_now = stop_pend_reg | cfg_stop;
    start_ok = (state_reg == ST_IDLE) & cfg_start & (cfg_len != '0) & ~cfg_stop;
    ld       = 1'b0;
    nb_base  = base_reg;
    nb_off   = off_reg + 8'(BYTES);
    nb_left  = beats_left_reg - LEN_WIDTH'(1);
`ifdef AXIS_PKT_GEN_TKEEP_EN
    nb_rem   = rem_reg - BYTES_L;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (start_ok) begin
          ld      = 1'b1;
          nb_base = cfg_seed;
          nb_off  = 8'd0;
          nb_left = start_beats;
`ifdef AXIS_PKT_GEN_TKEEP_EN
          nb_rem  = cfg_len;
`endif
        end
      end
      ST_SEND: begin
        if (hs && !tlast_reg) begin
          ld = 1'b1;
        end else if (last_hs && more && !stop_now && gap_reg == '0) begin
          ld      = 1'b1;
          nb_base = base_reg + 8'd1;
          nb_off  = 8'd0;
          nb_left = beats_reg;
`ifdef AXIS_PKT_GEN_TKEEP_EN
          nb_rem  = len_reg;
`endif
        end
      end
      ST_GAP: begin
        if (!cfg_stop && gap_cnt_reg == GAP_WIDTH'(1)) begin
          ld      = 1'b1;
          nb_off  = 8'd0;
          nb_left = beats_reg;
`ifdef AXIS_PKT_GEN_TKEEP_EN
          nb_rem  = len_reg;
`endif
        end
      end
      default: ;
    endcase
  end

  axis_pkt_gen_fmt #(
    .DATA_WIDTH(DATA_WIDTH)
`ifdef AXIS_PKT_GEN_TKEEP_EN
    ,
    .LEN_WIDTH (LEN_WIDTH)
`endif
  ) u_fmt (
    .base(nb_base),
    .off (nb_off),
`ifdef AXIS_PKT_GEN_TKEEP_EN
    .rem (nb_rem),
    .keep(fmt_keep),
`endif
    .data(fmt_data)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_reg      <= ST_IDLE;
      beats_reg      <= '0;
      beats_left_reg <= '0;
      count_reg      <= '0;
      pkt_cnt_reg    <= '0;
      gap_reg        <= '0;
      gap_cnt_reg    <= '0;
      base_reg       <= '0;
      off_reg        <= '0;
      stop_pend_reg  <= 1'b0;
      pkt_done_reg   <= 1'b0;
      tvalid_reg     <= 1'b0;
      tlast_reg      <= 1'b0;
      tdata_reg      <= '0;
`ifdef AXIS_PKT_GEN_TKEEP_EN
      len_reg        <= '0;
      rem_reg        <= '0;
      tkeep_reg      <= '0;
`endif
    end else begin
      pkt_done_reg <= 1'b0;
      if (ld) begin
        tvalid_reg     <= 1'b1;
        tdata_reg      <= fmt_data;
        tlast_reg      <= (nb_left == LEN_WIDTH'(1));
        base_reg       <= nb_base;
        off_reg        <= nb_off;
        beats_left_reg <= nb_left;
`ifdef AXIS_PKT_GEN_TKEEP_EN
        rem_reg        <= nb_rem;
        tkeep_reg      <= fmt_keep;
`endif
      end
      case (state_reg)
        ST_IDLE: begin
          if (start_ok) begin
            state_reg     <= ST_SEND;
            beats_reg     <= start_beats;
            count_reg     <= cfg_count;
            gap_reg       <= cfg_gap;
            pkt_cnt_reg   <= 16'd0;
            stop_pend_reg <= 1'b0;
`ifdef AXIS_PKT_GEN_TKEEP_EN
            len_reg       <= cfg_len;
`endif
          end
        end
        ST_SEND: begin
          if (cfg_stop) stop_pend_reg <= 1'b1;
          if (last_hs) begin
            pkt_done_reg <= 1'b1;
            pkt_cnt_reg  <= pkt_cnt_reg + 16'd1;
            if (more && !stop_now) begin
              if (gap_reg != '0) begin
                state_reg   <= ST_GAP;
                gap_cnt_reg <= gap_reg;
                base_reg    <= base_reg + 8'd1;
                tvalid_reg  <= 1'b0;
                tlast_reg   <= 1'b0;
              end
            end else begin
              state_reg  <= ST_IDLE;
              tvalid_reg <= 1'b0;
              tlast_reg  <= 1'b0;
            end
          end
        end
        ST_GAP: begin
          if (cfg_stop)                           state_reg   <= ST_IDLE;
          else if (gap_cnt_reg == GAP_WIDTH'(1))  state_reg   <= ST_SEND;
          else                                    gap_cnt_reg <= gap_cnt_reg - GAP_WIDTH'(1);
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign busy          = (state_reg != ST_IDLE);
  assign pkt_done      = pkt_done_reg;
  assign pkt_cnt       = pkt_cnt_reg;
  assign m_axis_tvalid = tvalid_reg;
  assign m_axis_tdata  = tdata_reg;
  assign m_axis_tlast  = tlast_reg;
`ifdef AXIS_PKT_GEN_TKEEP_EN
  assign m_axis_tkeep  = tkeep_reg;
`endif

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Scoreboard testbench for axis_pkt_gen (32-bit stream); works with or without AXIS_PKT_GEN_TKEEP_EN.
module tb_axis_pkt_gen;

  localparam int DW = 32;
  localparam int B  = DW / 8;

  logic          aclk = 1'b0, areset = 1'b1, cfg_start = 1'b0, cfg_stop = 1'b0, m_axis_tready = 1'b0;
  logic [15:0]   cfg_len = '0, cfg_count = '0;
  logic [7:0]    cfg_gap = '0, cfg_seed = '0;
  logic          busy, pkt_done, m_axis_tvalid, m_axis_tlast;
  logic [15:0]   pkt_cnt;
  logic [DW-1:0] m_axis_tdata;
`ifdef AXIS_PKT_GEN_TKEEP_EN
  logic [B-1:0]  m_axis_tkeep;
`endif

  int errors = 0, checks = 0, beats_seen = 0, rdy_mode = 0, pat_i = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [B-1:0]  keep;
    int            gap;   // idle cycles expected before this beat; negative = not checked
  } beat_t;
  beat_t exp_q[$];

  always #5 aclk = ~aclk;

  axis_pkt_gen #(.DATA_WIDTH(DW), .LEN_WIDTH(16), .GAP_WIDTH(8)) dut (
    .aclk         (aclk),
    .areset       (areset),
    .cfg_start    (cfg_start),
    .cfg_len      (cfg_len),
    .cfg_count    (cfg_count),
    .cfg_gap      (cfg_gap),
    .cfg_seed     (cfg_seed),
    .cfg_stop     (cfg_stop),
    .busy         (busy),
    .pkt_done     (pkt_done),
    .pkt_cnt      (pkt_cnt),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tlast (m_axis_tlast)
`ifdef AXIS_PKT_GEN_TKEEP_EN
    ,
    .m_axis_tkeep (m_axis_tkeep)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: byte i of packet p is (seed + p + i) mod 256.
  task automatic push_pkts(input int len, input int n, input int gap, input int seed);
    int beats;
    beats = (len + B - 1) / B;
    for (int p = 0; p < n; p++) begin
      for (int b = 0; b < beats; b++) begin
        beat_t e;
        e.data = '0;
        e.keep = '0;
        for (int j = 0; j < B; j++) begin
          int idx;
          logic [7:0] v;
          idx = b * B + j;
          v = 8'((seed + p + idx) % 256);
`ifdef AXIS_PKT_GEN_TKEEP_EN
          if (idx < len) begin
            e.data[j*8 +: 8] = v;
            e.keep[j] = 1'b1;
          end
`else
          e.data[j*8 +: 8] = v;
          e.keep[j] = 1'b1;
`endif
        end
        e.last = (b == beats - 1);
        e.gap  = (b != 0) ? -2 : ((p == 0) ? -1 : gap);
        exp_q.push_back(e);
      end
    end
  endtask

  // tready driver
  always @(posedge aclk) begin
    #1;
    case (rdy_mode)
      0: m_axis_tready = 1'b1;
      1: m_axis_tready = ($urandom_range(0, 3) != 0);
      default: begin
        m_axis_tready = (pat_i == 0);
        pat_i = (pat_i + 1) % 3;
      end
    endcase
  end

  // Monitor: pops the scoreboard on each handshake, checks stalls, pkt_done timing and gaps.
  logic          exp_done = 1'b0, stall_prev = 1'b0, last_prev = 1'b0;
  logic [DW-1:0] data_prev = '0;
  int            idle_cnt = 0;
  beat_t         mon_e;

  always @(negedge aclk) begin
    if (areset) begin
      exp_done   = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (exp_done || pkt_done) chk("pkt_done", 64'(pkt_done), 64'(exp_done));
      exp_done = 1'b0;
      if (stall_prev) begin
        chk("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
        chk("stall_tdata", 64'(m_axis_tdata), 64'(data_prev));
        chk("stall_tlast", 64'(m_axis_tlast), 64'(last_prev));
      end
      if (!m_axis_tvalid) idle_cnt++;
      if (m_axis_tvalid && m_axis_tready) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got tdata %0h, expected no beat", m_axis_tdata);
        end else begin
          mon_e = exp_q.pop_front();
          chk("tdata", 64'(m_axis_tdata), 64'(mon_e.data));
          chk("tlast", 64'(m_axis_tlast), 64'(mon_e.last));
`ifdef AXIS_PKT_GEN_TKEEP_EN
          chk("tkeep", 64'(m_axis_tkeep), 64'(mon_e.keep));
`endif
          if (mon_e.gap >= 0) chk("gap_idle_cycles", 64'(idle_cnt), 64'(mon_e.gap));
          if (mon_e.last) begin
            exp_done = 1'b1;
            idle_cnt = 0;
          end
        end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      data_prev  = m_axis_tdata;
      last_prev  = m_axis_tlast;
    end
  end

  task automatic start_run(input int len, input int count, input int gap, input int seed);
    @(posedge aclk); #1;
    cfg_len   = 16'(len);
    cfg_count = 16'(count);
    cfg_gap   = 8'(gap);
    cfg_seed  = 8'(seed);
    cfg_start = 1'b1;
    @(posedge aclk); #1;
    cfg_start = 1'b0;
    @(negedge aclk);
    chk("tvalid_latency", 64'(m_axis_tvalid), 64'd1);
    chk("busy_on_start", 64'(busy), 64'd1);
  endtask

  task automatic wait_beats(input int target, input string name);
    int n;
    n = 0;
    do begin
      @(posedge aclk); #1;
      n++;
    end while (beats_seen < target && n < 2000);
    if (beats_seen < target) begin
      checks++;
      errors++;
      $display("FAIL %s_beat_timeout: got %0d beats, expected %0d", name, beats_seen, target);
    end
  endtask

  task automatic wait_idle(input string name, input int exp_cnt);
    int n;
    n = 0;
    while (busy && n < 4000) begin
      @(posedge aclk); #1;
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles, expected 0", name, n);
      areset = 1'b1;
      @(posedge aclk); #1;
      areset = 1'b0;
    end
    repeat (3) @(posedge aclk);
    #1;
    chk({name, "_pkt_cnt"}, 64'(pkt_cnt), 64'(exp_cnt));
    chk({name, "_queue_left"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic idle_hold(input string name, input int cycles);
    logic bad;
    bad = 1'b0;
    repeat (cycles) begin
      @(negedge aclk);
      if (busy || m_axis_tvalid) bad = 1'b1;
    end
    chk(name, 64'(bad), 64'd0);
  endtask

  initial begin
    int base;
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, len, cnt, gap, seed;
    #12;
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pkt_done", 64'(pkt_done), 64'd0);
    chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
`ifdef AXIS_PKT_GEN_TKEEP_EN
    chk("rst_tkeep", 64'(m_axis_tkeep), 64'd0);
`endif
    @(posedge aclk); #1;
    areset = 1'b0;
    idle_hold("idle_after_reset_release", 3);

    // 10 bytes, seed 0x10, back-to-back-free single packet
    rdy_mode = 0;
    push_pkts(10, 1, 0, 8'h10);
    start_run(10, 1, 0, 8'h10);
    wait_idle("single_pkt", 1);

    // three packets with two idle cycles between them
    push_pkts(4, 3, 2, 8'h20);
    start_run(4, 3, 2, 8'h20);
    wait_idle("gap2", 3);

    // backpressure 1,0,0 pattern
    rdy_mode = 2;
    push_pkts(10, 1, 0, 8'h55);
    start_run(10, 1, 0, 8'h55);
    wait_idle("backpressure", 1);
    push_pkts(7, 2, 1, 8'hF0);
    start_run(7, 2, 1, 8'hF0);
    wait_idle("backpressure_gap", 2);
    rdy_mode = 0;

    // continuous mode, stop during beat 2 of packet 1
    base = beats_seen;
    push_pkts(16, 2, 0, 8'h80);
    start_run(16, 0, 0, 8'h80);
    wait_beats(base + 5, "stop_send");
    cfg_stop = 1'b1;
    @(posedge aclk); #1;
    cfg_stop = 1'b0;
    wait_idle("stop_send", 2);
    idle_hold("no_tvalid_after_stop", 4);

    // continuous mode, stop while in the gap
    base = beats_seen;
    push_pkts(4, 1, 4, 8'h07);
    start_run(4, 0, 4, 8'h07);
    wait_beats(base + 1, "stop_gap");
    cfg_stop = 1'b1;
    @(posedge aclk); #1;
    cfg_stop = 1'b0;
    wait_idle("stop_gap", 1);

    // reset during beat 2 of 5
    base = beats_seen;
    push_pkts(20, 1, 0, 8'h33);
    start_run(20, 1, 0, 8'h33);
    wait_beats(base + 1, "reset_mid");
    #2;
    areset = 1'b1;
    #1;
    chk("async_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("async_rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    idle_hold("tvalid_low_after_reset", 5);
    chk("pkt_cnt_after_reset", 64'(pkt_cnt), 64'd0);
    push_pkts(20, 1, 0, 8'h33);
    start_run(20, 1, 0, 8'h33);
    wait_idle("restart_after_reset", 1);

    // ignored starts: len 0, and start together with stop
    @(posedge aclk); #1;
    cfg_len = 16'd0; cfg_count = 16'd2; cfg_start = 1'b1;
    @(posedge aclk); #1;
    cfg_start = 1'b0;
    idle_hold("len0_ignored", 4);
    chk("len0_pkt_cnt_kept", 64'(pkt_cnt), 64'd1);
    @(posedge aclk); #1;
    cfg_len = 16'd8; cfg_start = 1'b1; cfg_stop = 1'b1;
    @(posedge aclk); #1;
    cfg_start = 1'b0; cfg_stop = 1'b0;
    idle_hold("stop_beats_start", 4);

    // start while busy is ignored
    push_pkts(8, 2, 3, 8'h40);
    start_run(8, 2, 3, 8'h40);
    @(posedge aclk); #1;
    cfg_len = 16'd4; cfg_count = 16'd5; cfg_seed = 8'h99; cfg_gap = 8'd0; cfg_start = 1'b1;
    @(posedge aclk); #1;
    cfg_start = 1'b0;
    wait_idle("start_while_busy", 2);

    // randomized runs
    for (int t = 0; t < 10; t++) begin
      len  = $urandom_range(1, 24);
      cnt  = $urandom_range(1, 3);
      gap  = $urandom_range(0, 3);
      seed = $urandom_range(0, 255);
      rdy_mode = $urandom_range(0, 1);
      push_pkts(len, cnt, gap, seed);
      start_run(len, cnt, gap, seed);
      wait_idle("random", cnt);
    end
    rdy_mode = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_pkt_gen.md
AXIS_PKT_GEN -- requirements
Module: axis_pkt_gen

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: tdata width in bits; multiple of 8, range 8..512; BYTES = DATA_WIDTH/8.
REQ-002 The block SHALL have parameter LEN_WIDTH, default 16: width of the packet length in bytes.
REQ-003 The block SHALL have parameter GAP_WIDTH, default 8: width of the inter-packet idle count.
REQ-004 The block SHALL have port aclk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port areset, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port cfg_start, input, 1 bit: single-cycle start request.
REQ-007 The block SHALL have port cfg_len, input, LEN_WIDTH bits: bytes per packet.
REQ-008 The block SHALL have port cfg_count, input, 16 bits: packets to send; 0 means continuous until stopped.
REQ-009 The block SHALL have port cfg_gap, input, GAP_WIDTH bits: idle cycles between packets.
REQ-010 The block SHALL have port cfg_seed, input, 8 bits: first byte value.
REQ-011 The block SHALL have port cfg_stop, input, 1 bit: stop request.
REQ-012 The block SHALL have port busy, output, 1 bit: high while not IDLE.
REQ-013 The block SHALL have port pkt_done, output, 1 bit: one-cycle pulse per completed packet.
REQ-014 The block SHALL have port pkt_cnt, output, 16 bits: packets completed since the last start.
REQ-015 The block SHALL have ports m_axis_tvalid (output, 1), m_axis_tready (input, 1), m_axis_tdata (output, DATA_WIDTH) and m_axis_tlast (output, 1): the AXI4-Stream master.
REQ-016 The block SHALL have port m_axis_tkeep, output, BYTES bits, present only when AXIS_PKT_GEN_TKEEP_EN is defined.

Function
REQ-017 The block SHALL implement states IDLE, SEND and GAP.
- IDLE->SEND: cfg_start with cfg_len!=0; cfg_len, cfg_count, cfg_gap and cfg_seed are captured and pkt_cnt is cleared.
- SEND->GAP: on the final-beat handshake when more packets remain and cfg_gap!=0.
- SEND->SEND (back-to-back): on the final-beat handshake when more packets remain and cfg_gap==0.
- GAP->SEND: after exactly cfg_gap idle cycles.
- Any->IDLE: after the last packet of cfg_count.
REQ-018 In IDLE, cfg_start with cfg_len==0 SHALL be ignored, and cfg_start while busy SHALL be ignored.
REQ-019 m_axis_tvalid SHALL rise in the cycle after the accepted cfg_start, with latency 1.
REQ-020 While tvalid=1 and tready=0, tdata, tlast and tkeep SHALL stay stable, and tvalid SHALL NOT drop.
REQ-021 Beats per packet SHALL be ceil(len/BYTES), with tlast=1 only on the final beat.
REQ-022 Byte i of packet p (p counted from 0) SHALL equal (seed + p + i) mod 256, with lane 0 holding the lowest i.
REQ-023 pkt_done SHALL pulse in the cycle after each final-beat handshake, and pkt_cnt SHALL increment in that same cycle, wrapping at 2^16.
REQ-024 cfg_stop SHALL never truncate a packet.
- In SEND, the current packet completes, then the block goes to IDLE.
- In GAP, the block goes to IDLE on the next cycle.
- cfg_stop together with cfg_start in IDLE: stop wins.
REQ-025 With cfg_count=0 the block SHALL run until cfg_stop, and pkt_cnt SHALL wrap silently.

Reset
REQ-026 On areset the block SHALL asynchronously enter IDLE with tvalid=0, tlast=0, tdata=0, tkeep=0, busy=0, pkt_done=0 and pkt_cnt=0.
REQ-027 Reset asserted mid-packet SHALL abandon the packet immediately, with no tlast issued.
REQ-028 After reset deassertion, tvalid SHALL remain 0 until a new cfg_start is accepted.

Configuration
REQ-029 When AXIS_PKT_GEN_TKEEP_EN is defined, m_axis_tkeep SHALL exist.
- Non-final beats: all ones.
- Final beat: the low (len mod BYTES) bits set, or all ones if the remainder is 0.
- Data bytes with keep=0 are driven to 0.
REQ-030 When AXIS_PKT_GEN_TKEEP_EN is undefined, no tkeep port SHALL exist, and final-beat padding bytes SHALL continue the REQ-022 pattern.

Structure
REQ-031 A shared package axis_pkt_gen_pkg SHALL hold the state enum type and a beat-count function ceil(len, bytes).
REQ-032 One sub-module, axis_pkt_gen_fmt, SHALL be used: combinational beat formatter producing tdata and tkeep from seed, packet index, byte offset and remaining length.

Verification
REQ-033 DATA_WIDTH=32, len=10, count=1, seed=0x10, gap=0, tready=1: 3 beats; tdata 0x13121110, 0x17161514, then 0x????1918; tlast on beat 3; tkeep 0xF, 0xF, 0x3 with the macro; pkt_done one cycle later; pkt_cnt=1; busy=0.
REQ-034 DATA_WIDTH=8, len=4, count=3, gap=2, tready=1: 12 beats; exactly 2 idle cycles between packets; packet 1 starts with seed+1; pkt_cnt=3.
REQ-035 Backpressure, tready toggling 1,0,0,1,... on DATA_WIDTH=16, len=6: tdata and tlast stable while stalled; 3 handshakes total; byte order preserved.
REQ-036 count=0, gap=0, cfg_stop asserted mid-beat 2 of 4: packet finishes with tlast, then IDLE; no further tvalid.
REQ-037 areset asserted during beat 2 of 5: tvalid=0 asynchronously; after release, tvalid stays 0 until cfg_start; the next packet restarts at seed with pkt_cnt=0.
REQ-038 cfg_start with len=0, and cfg_start while busy: both ignored; state and outputs unchanged.
